// File: rtl/lock_pkg.sv
// Shared types and defaults for the keypad lock attempt guard.
package lock_pkg;

    localparam int unsigned KEY_W              = 4;
    localparam int unsigned MAX_FAIL_DEF       = 3;
    localparam int unsigned LOCKOUT_CYCLES_DEF = 50_000_000;
    localparam int unsigned ENTRY_TIMEOUT_DEF  = 250_000_000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_LOCKOUT = 2'd2
    } lock_state_e;

    // Escalation level steps 0 -> 1 -> 2 and stays at 2 (4x lockout).
    function automatic logic [1:0] esc_next(input logic [1:0] lvl);
        return (lvl >= 2'd2) ? 2'd2 : lvl + 2'd1;
    endfunction

endpackage

// File: rtl/guard_timer.sv
// Loadable saturating counter (up or down) with clear, enable and terminal-count compare.
module guard_timer #(
    parameter int unsigned W        = 32,
    parameter bit          COUNT_UP = 1'b1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic [W-1:0] tc_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Clear beats load beats count; both directions stop at their rail.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            if (COUNT_UP) begin
                if (cnt_q != '1) cnt_d = cnt_q + W'(1);
            end else begin
                if (cnt_q != '0) cnt_d = cnt_q - W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/lock_attempt_guard.sv
// Key-event gate between keypad scanner and lock decider: entry timeout, fail counting, lockout.
// Optional macro LOCKOUT_ESCALATE_EN doubles the lockout per successive lockout (up to 4x) and adds esc_level.
module lock_attempt_guard
    import lock_pkg::*;
#(
    parameter int unsigned MAX_FAIL       = MAX_FAIL_DEF,
    parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF,
    parameter int unsigned ENTRY_TIMEOUT  = ENTRY_TIMEOUT_DEF,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned FC_W           = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [KEY_W-1:0] Code_in,
    input  logic             Valid_in,
    input  logic             pass,
    input  logic             fail,
    output logic [KEY_W-1:0] Code_out,
    output logic             Valid_out,
    output logic             clear_entry,
    output logic             lockout,
    output logic [FC_W-1:0]  fail_count,
    output logic [CNT_W-1:0] lock_remain
`ifdef LOCKOUT_ESCALATE_EN
    ,
    output logic [1:0]       esc_level
`endif
);

    localparam logic [CNT_W-1:0] LOCK_BASE = CNT_W'(LOCKOUT_CYCLES);
    localparam logic [CNT_W-1:0] ENT_LAST  = CNT_W'(ENTRY_TIMEOUT - 1);
    localparam logic [FC_W-1:0]  FAIL_LAST = FC_W'(MAX_FAIL - 1);

    lock_state_e      state_q;
    logic [KEY_W-1:0] code_q;
    logic             valid_q, clear_q, lockout_q;
    logic [FC_W-1:0]  fail_cnt_q;

    logic             not_lock, key_acc, fail_ev, pass_ev, lock_enter, timeout;
    logic             ent_tc, lock_tc, ent_clr;
    logic [CNT_W-1:0] lock_len, lock_cnt;
    logic [CNT_W-1:0] ent_cnt_unused;

    assign not_lock   = (state_q != ST_LOCKOUT);
    assign key_acc    = Valid_in && not_lock;
    // Simultaneous pass and fail is treated as fail.
    assign fail_ev    = fail && not_lock;
    assign pass_ev    = pass && !fail && not_lock;
    assign lock_enter = fail_ev && (fail_cnt_q == FAIL_LAST);
    assign timeout    = (state_q == ST_ENTRY) && ent_tc && !key_acc && !fail_ev && !pass_ev;

`ifdef LOCKOUT_ESCALATE_EN
    logic [1:0] esc_q;

    assign lock_len  = LOCK_BASE << esc_q;
    assign esc_level = esc_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)          esc_q <= 2'd0;
        else if (lock_enter) esc_q <= esc_next(esc_q);
        else if (pass_ev)    esc_q <= 2'd0;
    end
`else
    assign lock_len = LOCK_BASE;
`endif

    // Entry timer only runs in ENTRY; any key, verdict or expiry restarts it.
    assign ent_clr = (state_q != ST_ENTRY) || key_acc || fail_ev || pass_ev || ent_tc;

    guard_timer #(.W(CNT_W), .COUNT_UP(1'b1)) u_entry_timer (
        .clk_i      (clock),
        .rst_ni     (reset),
        .clr_i      (ent_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (state_q == ST_ENTRY),
        .tc_val_i   (ENT_LAST),
        .cnt_o      (ent_cnt_unused),
        .tc_o       (ent_tc)
    );

    guard_timer #(.W(CNT_W), .COUNT_UP(1'b0)) u_lock_timer (
        .clk_i      (clock),
        .rst_ni     (reset),
        .clr_i      (1'b0),
        .load_i     (lock_enter),
        .load_val_i (lock_len),
        .en_i       (state_q == ST_LOCKOUT),
        .tc_val_i   (CNT_W'(1)),
        .cnt_o      (lock_cnt),
        .tc_o       (lock_tc)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            code_q     <= '0;
            valid_q    <= 1'b0;
            clear_q    <= 1'b0;
            lockout_q  <= 1'b0;
            fail_cnt_q <= '0;
        end else begin
            valid_q <= 1'b0;
            clear_q <= 1'b0;
            case (state_q)
                ST_LOCKOUT: begin
                    if (lock_tc) begin
                        state_q   <= ST_IDLE;
                        lockout_q <= 1'b0;
                    end
                end
                default: begin
                    if (lock_enter) begin
                        // A key in the same cycle as the final failure is dropped.
                        state_q    <= ST_LOCKOUT;
                        lockout_q  <= 1'b1;
                        clear_q    <= 1'b1;
                        fail_cnt_q <= '0;
                    end else begin
                        if (key_acc) begin
                            valid_q <= 1'b1;
                            code_q  <= Code_in;
                        end
                        if (fail_ev)      fail_cnt_q <= fail_cnt_q + FC_W'(1);
                        else if (pass_ev) fail_cnt_q <= '0;

                        if (key_acc) begin
                            state_q <= ST_ENTRY;
                        end else if (fail_ev || pass_ev) begin
                            state_q <= ST_IDLE;
                        end else if (timeout) begin
                            state_q <= ST_IDLE;
                            clear_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign Code_out    = code_q;
    assign Valid_out   = valid_q;
    assign clear_entry = clear_q;
    assign lockout     = lockout_q;
    assign fail_count  = fail_cnt_q;
    assign lock_remain = lock_cnt;

endmodule

// File: tb/tb_lock_attempt_guard.sv
// Randomized and directed bench for lock_attempt_guard against a cycle-level behavioural model.
module tb_lock_attempt_guard;

    localparam int MF = 3;
    localparam int LC = 20;
    localparam int ET = 10;
    localparam int CW = 32;
    localparam int FW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    Code_in = '0;
    logic          Valid_in = 1'b0;
    logic          pass = 1'b0;
    logic          fail = 1'b0;
    logic [3:0]    Code_out;
    logic          Valid_out, clear_entry, lockout;
    logic [FW-1:0] fail_count;
    logic [CW-1:0] lock_remain;
`ifdef LOCKOUT_ESCALATE_EN
    logic [1:0]    esc_level;
`endif

    lock_attempt_guard #(
        .MAX_FAIL(MF), .LOCKOUT_CYCLES(LC), .ENTRY_TIMEOUT(ET), .CNT_W(CW), .FC_W(FW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .Code_in     (Code_in),
        .Valid_in    (Valid_in),
        .pass        (pass),
        .fail        (fail),
        .Code_out    (Code_out),
        .Valid_out   (Valid_out),
        .clear_entry (clear_entry),
        .lockout     (lockout),
        .fail_count  (fail_count),
        .lock_remain (lock_remain)
`ifdef LOCKOUT_ESCALATE_EN
        ,
        .esc_level   (esc_level)
`endif
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model: "locked for N more cycles", "typing, idle for K cycles", fail tally.
    bit         m_lock, m_entry, e_valid, e_clear;
    int         m_rem, m_idle, m_fails, m_lvl;
    logic [3:0] e_code;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_lock = 0; m_entry = 0; e_valid = 0; e_clear = 0;
        m_rem = 0; m_idle = 0; m_fails = 0; m_lvl = 0; e_code = '0;
    endtask

    task automatic model_step(input bit v, input logic [3:0] c, input bit p, input bit f);
        e_valid = 0;
        e_clear = 0;
        if (m_lock) begin
            m_rem--;
            if (m_rem == 0) m_lock = 0;
        end else if (f && m_fails == MF - 1) begin
            m_fails = 0;
            m_lock  = 1;
            m_entry = 0;
            e_clear = 1;
`ifdef LOCKOUT_ESCALATE_EN
            m_rem = LC * (1 << m_lvl);
            m_lvl = (m_lvl < 2) ? m_lvl + 1 : 2;
`else
            m_rem = LC;
`endif
        end else begin
            if (v) begin
                e_valid = 1;
                e_code  = c;
            end
            if (f) m_fails++;
            else if (p) begin
                m_fails = 0;
                m_lvl   = 0;
            end
            if (f || p) begin
                m_entry = v;
                m_idle  = 0;
            end else if (v) begin
                m_entry = 1;
                m_idle  = 0;
            end else if (m_entry) begin
                if (m_idle == ET - 1) begin
                    e_clear = 1;
                    m_entry = 0;
                    m_idle  = 0;
                end else begin
                    m_idle++;
                end
            end
        end
    endtask

    task automatic check_all();
        check("Valid_out",   Valid_out,   e_valid);
        check("Code_out",    Code_out,    e_code);
        check("clear_entry", clear_entry, e_clear);
        check("lockout",     lockout,     m_lock);
        check("fail_count",  fail_count,  m_fails);
        check("lock_remain", lock_remain, m_rem);
`ifdef LOCKOUT_ESCALATE_EN
        check("esc_level",   esc_level,   m_lvl);
`endif
    endtask

    task automatic cyc(input bit v, input logic [3:0] c, input bit p, input bit f);
        Valid_in = v; Code_in = c; pass = p; fail = f;
        @(posedge clock);
        model_step(v, c, p, f);
        #1;
        check_all();
        Valid_in = 0; pass = 0; fail = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 4'h0, 0, 0);
    endtask

    task automatic wait_unlock();
        for (int i = 0; i < 400 && m_lock; i++) cyc(1'($urandom_range(0, 1)), 4'($urandom), 0, 0);
        check("unlock_bound", lockout, 1'b0);
    endtask

    initial begin
        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Forwarding, entry timeout, and a key just before the timeout
        cyc(1, 4'h5, 0, 0);
        idle(ET);
        cyc(1, 4'h3, 0, 0);
        idle(ET - 2);
        cyc(1, 4'h7, 0, 0);
        idle(ET + 2);

        // Three failures -> lockout, keys suppressed throughout
        for (int i = 0; i < 3; i++) cyc(0, 4'h0, 0, 1);
        wait_unlock();
        cyc(1, 4'h9, 0, 0);

        // fail, fail, pass, fail; then pass+fail at count 2
        cyc(0, 4'h0, 0, 1);
        cyc(0, 4'h0, 0, 1);
        cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 0, 1);
        idle(2);
        cyc(0, 4'h0, 0, 1);
        cyc(1, 4'h2, 1, 1);
        wait_unlock();

        // Successive lockouts (escalation when enabled), then pass resets level
        cyc(0, 4'h0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) cyc(0, 4'h0, 0, 1);
            wait_unlock();
        end
        cyc(1, 4'hC, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 4'h0, 0, 1);
        wait_unlock();

        // Randomized traffic with quiet stretches to hit timeouts
        for (int blk = 0; blk < 200; blk++) begin
            int vp;
            vp = ($urandom_range(0, 3) == 0) ? 0 : 35;
            for (int i = 0; i < 16; i++)
                cyc(1'($urandom_range(0, 99) < vp), 4'($urandom),
                    1'($urandom_range(0, 99) < 5), 1'($urandom_range(0, 99) < 8));
        end
        wait_unlock();

        // Asynchronous reset in the middle of a lockout
        cyc(0, 4'h0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 4'h0, 0, 1);
        for (int i = 0; i < 200 && m_rem != 7; i++) cyc(0, 4'h0, 0, 0);
        check("reach_rem7", lock_remain, 32'd7);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clock);
        reset = 1'b1;
        cyc(1, 4'hA, 0, 0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lock_attempt_guard.md
Name: lock_attempt_guard

Overview:
Security controller between the keypad scanner output (Code/Valid) and the lock decision FSM. It forwards key events, aborts stale partial entries after an inactivity timeout, and counts failed code attempts. After MAX_FAIL consecutive failures it imposes a timed lockout, during which all key events are suppressed. Instantiated in the top level, taking the scanner's Code/Valid and the decider's pass/fail result pulses.

Parameters:
MAX_FAIL, 3, consecutive failures that trigger lockout (2..15)
LOCKOUT_CYCLES, 50_000_000, lockout duration in clock cycles
ENTRY_TIMEOUT, 250_000_000, idle cycles after last accepted key before entry abort
CNT_W, 32, timer width; must satisfy 4*LOCKOUT_CYCLES and ENTRY_TIMEOUT < 2**CNT_W
FC_W, 4, fail counter width

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
Code_in  input  4  key code from scanner, qualified by Valid_in
Valid_in  input  1  one-cycle key-event pulse
pass  input  1  one-cycle pulse: correct code accepted
fail  input  1  one-cycle pulse: wrong code rejected
Code_out  output  4  registered key code to decider
Valid_out  output  1  registered, gated key-event pulse
clear_entry  output  1  one-cycle pulse: decider must discard partial entry
lockout  output  1  high throughout lockout
fail_count  output  FC_W  current consecutive-failure count
lock_remain  output  CNT_W  lockout cycles remaining; 0 outside lockout

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; Code_out=0, Valid_out=0, clear_entry=0, lockout=0, fail_count=0, lock_remain=0, timers=0.
- States: IDLE, ENTRY, LOCKOUT (registered state, one-hot or binary).
- Key forwarding: an accepted key (Valid_in=1, state != LOCKOUT) produces Valid_out=1 and Code_out=Code_in one cycle later (latency 1). Code_out holds its last value otherwise. In LOCKOUT, keys are dropped; Valid_out stays 0.
- IDLE: accepted key -> ENTRY, entry timer=0.
- ENTRY: each accepted key clears the entry timer; otherwise the timer increments. When the timer reaches ENTRY_TIMEOUT-1 with no key that cycle: clear_entry=1 for the next cycle, -> IDLE, fail_count unchanged. Key and timeout in the same cycle: the key wins and the timer restarts.
- pass (IDLE or ENTRY): fail_count=0, -> IDLE.
- fail (IDLE or ENTRY): if fail_count == MAX_FAIL-1, then fail_count=0, -> LOCKOUT, lock_remain=LOCKOUT_CYCLES, clear_entry pulses. Otherwise fail_count+1 and -> IDLE.
- pass and fail in the same cycle are treated as fail (fail-safe).
- LOCKOUT: lockout=1; lock_remain decrements each cycle. When lock_remain is 1: next cycle lock_remain=0, lockout=0, -> IDLE. pass and fail are ignored.
- A key arriving in the same cycle that the FSM leaves LOCKOUT is still dropped. Keys are accepted from the first IDLE cycle.
- A key arriving in the same cycle as pass/fail is forwarded and the FSM goes to ENTRY (unless entering LOCKOUT, which drops it).
- The timer saturates and never wraps. Counter arithmetic is unsigned; comparisons are at full width.

Optional Feature:
LOCKOUT_ESCALATE_EN: when defined, a 2-bit escalation level sets the lockout duration to LOCKOUT_CYCLES << level. The level increments on each lockout entry, saturates at 2 (4x), and clears on pass. Output esc_level[1:0] is added, with reset value 0. When undefined, every lockout is exactly LOCKOUT_CYCLES and no esc_level port exists.

Decomposition:
- Shared package lock_pkg: state enum (IDLE/ENTRY/LOCKOUT), key-code width constant (4), default timing constants.
- One sub-module, guard_timer: loadable down/up counter with load, clear, enable and terminal-count outputs. It is instantiated twice, once for the entry timeout and once for the lockout. The FSM and gating stay in the top.

Test Plan:
All scenarios use MAX_FAIL=3, LOCKOUT_CYCLES=20, ENTRY_TIMEOUT=10.
- Reset mid-lockout: assert reset at lock_remain=7 -> all outputs 0 immediately (asynchronously); keys are accepted after reset release.
- Key 4'h5 in IDLE -> Valid_out=1, Code_out=5 exactly 1 cycle later; state ENTRY.
- Key, then 10 idle cycles -> clear_entry is a single-cycle pulse after cycle 10; state IDLE; fail_count unchanged. Key on cycle 9 -> no clear_entry.
- Three fail pulses -> fail_count goes 1, 2, then 0 with lockout=1 and lock_remain=20. Keys during the 20 cycles -> no Valid_out. lockout falls after exactly 20 cycles.
- fail, fail, pass, fail -> fail_count=1 and no lockout. pass and fail in the same cycle at fail_count=2 -> lockout entered.
- With LOCKOUT_ESCALATE_EN: three successive lockouts last 20, 40 and 80 cycles, and a 4th also lasts 80. A pass then resets the next lockout to 20.
